// File: rtl/inst_queue_if.sv
// Producer/consumer bundle for inst_queue: grouped enqueue, dequeue and flush handshake.
// The queue side uses the slave modport; the driving pipeline stages use master.
interface inst_queue_if #(
  parameter int unsigned DATA_W = 64,
  parameter int unsigned LANES  = 2,
  parameter int unsigned DEPTH  = 8
);
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;
  localparam int unsigned DEQ_W = $clog2(LANES + 1);

  logic                      flush;
  logic [LANES-1:0]          in_valid;
  logic [LANES*DATA_W-1:0]   in_data;
  logic                      in_ready;
  logic [LANES-1:0]          out_valid;
  logic [LANES*DATA_W-1:0]   out_data;
  logic [DEQ_W-1:0]          out_deq;
  logic [CNT_W-1:0]          count;

  modport master (
    output flush, in_valid, in_data, out_deq,
    input  in_ready, out_valid, out_data, count
  );

  modport slave (
    input  flush, in_valid, in_data, out_deq,
    output in_ready, out_valid, out_data, count
  );
endinterface

// File: rtl/inst_queue.sv
// Multi-lane compacting decoupling queue between superscalar pipeline stages.
// Optional same-cycle bypass of an empty queue: define INST_QUEUE_BYPASS_EN.
module inst_queue #(
  parameter int unsigned DATA_W = 64,
  parameter int unsigned LANES  = 2,
  parameter int unsigned DEPTH  = 8
) (
  input logic         clk,
  input logic         reset,
  inst_queue_if.slave q
);
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned DEQ_W = $clog2(LANES + 1);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  head_q, head_d;
  logic [PTR_W-1:0]  tail_q, tail_d;
  logic [CNT_W-1:0]  count_q, count_d;

  logic [DATA_W-1:0] in_lane  [LANES];
  logic [DEQ_W-1:0]  lane_off [LANES];
  logic [PTR_W-1:0]  wr_idx   [LANES];
  logic [PTR_W-1:0]  rd_idx   [LANES];
  logic [LANES-1:0]  wr_en;
  logic [DEQ_W-1:0]  n_valid, n_in, n_out;
  logic [CNT_W-1:0]  avail;
  logic              in_ready, accept, bypass;

  // Readiness looks only at registered count, so no path from in_valid/out_deq.
  assign in_ready = (CNT_W'(DEPTH) - count_q) >= CNT_W'(LANES);
  assign accept   = in_ready && !q.flush;

  // Each valid lane lands at tail + (number of valid lanes below it).
  always_comb begin
    n_valid = '0;
    for (int i = 0; i < LANES; i++) begin
      in_lane[i]  = q.in_data[i*DATA_W +: DATA_W];
      lane_off[i] = n_valid;
      if (q.in_valid[i]) n_valid = n_valid + DEQ_W'(1);
    end
  end

  assign n_in = accept ? n_valid : '0;

`ifdef INST_QUEUE_BYPASS_EN
  assign bypass = (count_q == '0) && !q.flush;
`else
  assign bypass = 1'b0;
`endif

  // While bypassing, the consumer can only take what arrives this cycle.
  assign avail = bypass ? CNT_W'(n_in) : count_q;

  always_comb begin
    if (CNT_W'(q.out_deq) > avail) n_out = DEQ_W'(avail);
    else                           n_out = q.out_deq;
  end

  // Bypassed entries consumed this cycle occupy head..head+n_out-1 and are skipped.
  always_comb begin
    for (int i = 0; i < LANES; i++) begin
      wr_idx[i] = tail_q + PTR_W'(lane_off[i]);
      wr_en[i]  = accept && q.in_valid[i] && !(bypass && (lane_off[i] < n_out));
    end
  end

  always_comb begin
    if (q.flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      head_d  = head_q + PTR_W'(n_out);
      tail_d  = tail_q + PTR_W'(n_in);
      count_d = count_q + CNT_W'(n_in) - CNT_W'(n_out);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Storage needs no reset: out_data is masked by out_valid.
  always_ff @(posedge clk) begin
    for (int i = 0; i < LANES; i++) begin
      if (wr_en[i]) mem_q[wr_idx[i]] <= in_lane[i];
    end
  end

`ifdef INST_QUEUE_BYPASS_EN
  logic [DATA_W-1:0] byp_data [LANES];

  always_comb begin
    for (int k = 0; k < LANES; k++) byp_data[k] = '0;
    for (int i = 0; i < LANES; i++) begin
      if (q.in_valid[i]) byp_data[lane_off[i]] = in_lane[i];
    end
  end
`endif

  always_comb begin
    logic vld;
    q.out_valid = '0;
    q.out_data  = '0;
    for (int i = 0; i < LANES; i++) begin
      rd_idx[i] = head_q + PTR_W'(i);
      vld       = count_q > CNT_W'(i);
      q.out_valid[i] = vld;
      q.out_data[i*DATA_W +: DATA_W] = vld ? mem_q[rd_idx[i]] : '0;
`ifdef INST_QUEUE_BYPASS_EN
      if (bypass) begin
        vld            = CNT_W'(n_in) > CNT_W'(i);
        q.out_valid[i] = vld;
        q.out_data[i*DATA_W +: DATA_W] = vld ? byp_data[i] : '0;
      end
`endif
    end
  end

  assign q.in_ready = in_ready;
  assign q.count    = count_q;

  count_range: assert property (@(posedge clk) disable iff (reset) count_q <= CNT_W'(DEPTH));

endmodule

// File: tb/tb_inst_queue.sv
// Directed, table-driven bench for inst_queue (LANES=2, DEPTH=8, DATA_W=64).
// Same-cycle visibility expectations follow INST_QUEUE_BYPASS_EN.
module tb_inst_queue;
  localparam int unsigned DATA_W = 64;
  localparam int unsigned LANES  = 2;
  localparam int unsigned DEPTH  = 8;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_vec = 0;
  int   n_fail = 0;

  inst_queue_if #(.DATA_W(DATA_W), .LANES(LANES), .DEPTH(DEPTH)) qif ();

  inst_queue #(.DATA_W(DATA_W), .LANES(LANES), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .q     (qif)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        flush;
    logic [1:0]  in_valid;
    logic [63:0] d0;
    logic [63:0] d1;
    logic [1:0]  deq;
    logic [3:0]  e_count;
    logic [1:0]  e_valid;
    logic        e_ready;
    logic [63:0] e0;
    logic [63:0] e1;
  } vec_t;

  vec_t vecs[16];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  task automatic idle();
    qif.flush    = 1'b0;
    qif.in_valid = '0;
    qif.in_data  = '0;
    qif.out_deq  = '0;
  endtask

  task automatic drive(input logic fl, input logic [1:0] iv, input logic [63:0] d0,
                       input logic [63:0] d1, input logic [1:0] deq);
    qif.flush    = fl;
    qif.in_valid = iv;
    qif.in_data  = {d1, d0};
    qif.out_deq  = deq;
  endtask

  // Drive for one edge, then return to idle so outputs reflect stored state only.
  task automatic apply(input logic fl, input logic [1:0] iv, input logic [63:0] d0,
                       input logic [63:0] d1, input logic [1:0] deq);
    drive(fl, iv, d0, d1, deq);
    @(posedge clk);
    #1;
    idle();
    #1;
  endtask

  initial begin
    idle();
    vecs[0]  = '{1'b0, 2'b11, 64'hA,  64'hB,  2'd0, 4'd2, 2'b11, 1'b1, 64'hA,  64'hB};
    vecs[1]  = '{1'b0, 2'b00, 64'h0,  64'h0,  2'd2, 4'd0, 2'b00, 1'b1, 64'h0,  64'h0};
    vecs[2]  = '{1'b0, 2'b10, 64'hFF, 64'hC,  2'd0, 4'd1, 2'b01, 1'b1, 64'hC,  64'h0};
    vecs[3]  = '{1'b0, 2'b01, 64'hD,  64'h0,  2'd1, 4'd1, 2'b01, 1'b1, 64'hD,  64'h0};
    vecs[4]  = '{1'b0, 2'b11, 64'hE,  64'hF,  2'd0, 4'd3, 2'b11, 1'b1, 64'hD,  64'hE};
    vecs[5]  = '{1'b0, 2'b11, 64'h10, 64'h11, 2'd0, 4'd5, 2'b11, 1'b1, 64'hD,  64'hE};
    vecs[6]  = '{1'b0, 2'b11, 64'h12, 64'h13, 2'd0, 4'd7, 2'b11, 1'b0, 64'hD,  64'hE};
    vecs[7]  = '{1'b0, 2'b11, 64'h14, 64'h15, 2'd0, 4'd7, 2'b11, 1'b0, 64'hD,  64'hE};
    vecs[8]  = '{1'b0, 2'b11, 64'h16, 64'h17, 2'd2, 4'd5, 2'b11, 1'b1, 64'hF,  64'h10};
    vecs[9]  = '{1'b0, 2'b00, 64'h0,  64'h0,  2'd2, 4'd3, 2'b11, 1'b1, 64'h11, 64'h12};
    vecs[10] = '{1'b0, 2'b00, 64'h0,  64'h0,  2'd2, 4'd1, 2'b01, 1'b1, 64'h13, 64'h0};
    vecs[11] = '{1'b0, 2'b00, 64'h0,  64'h0,  2'd2, 4'd0, 2'b00, 1'b1, 64'h0,  64'h0};
    vecs[12] = '{1'b0, 2'b11, 64'h20, 64'h21, 2'd0, 4'd2, 2'b11, 1'b1, 64'h20, 64'h21};
    vecs[13] = '{1'b0, 2'b11, 64'h22, 64'h23, 2'd0, 4'd4, 2'b11, 1'b1, 64'h20, 64'h21};
    vecs[14] = '{1'b1, 2'b11, 64'h24, 64'h25, 2'd2, 4'd0, 2'b00, 1'b1, 64'h0,  64'h0};
    vecs[15] = '{1'b0, 2'b01, 64'h26, 64'h0,  2'd0, 4'd1, 2'b01, 1'b1, 64'h26, 64'h0};

    repeat (2) @(posedge clk);
    #1;
    check("reset count", 64'(qif.count), 64'd0);
    check("reset out_valid", 64'(qif.out_valid), 64'd0);
    check("reset in_ready", 64'(qif.in_ready), 64'd1);
    check("reset out_data", qif.out_data[63:0] | qif.out_data[127:64], 64'd0);
    reset = 1'b0;
    #1;

    for (int v = 0; v < 16; v++) begin
      apply(vecs[v].flush, vecs[v].in_valid, vecs[v].d0, vecs[v].d1, vecs[v].deq);
      check($sformatf("v%0d count", v), 64'(qif.count), 64'(vecs[v].e_count));
      check($sformatf("v%0d out_valid", v), 64'(qif.out_valid), 64'(vecs[v].e_valid));
      check($sformatf("v%0d in_ready", v), 64'(qif.in_ready), 64'(vecs[v].e_ready));
      if (vecs[v].e_valid[0]) check($sformatf("v%0d lane0", v), qif.out_data[63:0], vecs[v].e0);
      if (vecs[v].e_valid[1]) check($sformatf("v%0d lane1", v), qif.out_data[127:64], vecs[v].e1);
    end

    // Drain, then stream 2-in/2-out across several pointer wraps.
    apply(1'b0, 2'b00, 64'h0, 64'h0, 2'd1);
    check("drain count", 64'(qif.count), 64'd0);
    apply(1'b0, 2'b11, 64'd100, 64'd101, 2'd0);
    for (int k = 0; k < 20; k++) begin
      apply(1'b0, 2'b11, 64'(102 + 2*k), 64'(103 + 2*k), 2'd2);
      check($sformatf("wrap%0d count", k), 64'(qif.count), 64'd2);
      check($sformatf("wrap%0d lane0", k), qif.out_data[63:0], 64'(102 + 2*k));
      check($sformatf("wrap%0d lane1", k), qif.out_data[127:64], 64'(103 + 2*k));
    end
    apply(1'b0, 2'b00, 64'h0, 64'h0, 2'd2);
    check("wrap drain count", 64'(qif.count), 64'd0);

    // Same-cycle visibility of input into an empty queue.
    drive(1'b0, 2'b11, 64'hD0, 64'hE0, 2'd1);
    #1;
`ifdef INST_QUEUE_BYPASS_EN
    check("bypass out_valid", 64'(qif.out_valid), 64'd3);
    check("bypass lane0", qif.out_data[63:0], 64'hD0);
    check("bypass lane1", qif.out_data[127:64], 64'hE0);
    @(posedge clk);
    #1;
    idle();
    #1;
    check("bypass count", 64'(qif.count), 64'd1);
    check("bypass head", qif.out_data[63:0], 64'hE0);
`else
    check("no-bypass out_valid", 64'(qif.out_valid), 64'd0);
    @(posedge clk);
    #1;
    idle();
    #1;
    check("no-bypass count", 64'(qif.count), 64'd2);
    check("no-bypass head", qif.out_data[63:0], 64'hD0);
`endif

    // Asynchronous reset mid-cycle clears state without a clock edge.
    apply(1'b0, 2'b11, 64'h31, 64'h32, 2'd0);
    #1;
    reset = 1'b1;
    #1;
    check("async reset count", 64'(qif.count), 64'd0);
    check("async reset out_valid", 64'(qif.out_valid), 64'd0);
    check("async reset in_ready", 64'(qif.in_ready), 64'd1);
    @(posedge clk);
    #1;
    reset = 1'b0;
    apply(1'b0, 2'b01, 64'h41, 64'h0, 2'd0);
    check("post reset count", 64'(qif.count), 64'd1);
    check("post reset lane0", qif.out_data[63:0], 64'h41);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end
endmodule

// File: doc/inst_queue.md
# inst_queue

Parametrised multi-lane decoupling queue that replaces a fixed single-entry stall/flush stage register between two superscalar pipeline stages, e.g. fetch→decode or renaming→issue. Each cycle it accepts up to LANES entries with an arbitrary valid mask, compacting them in lane order. It presents up to LANES oldest entries in order and retires a consumer-chosen count of them. A one-cycle flush empties it on branch mispredict or exception.

## Interface
- DATA_W, 64, width of one entry (a packed per-lane stage payload)
- LANES, 2, lanes per side (equals MACHINE_WIDTH)
- DEPTH, 8, entries; power of two, ≥ 2·LANES
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  asynchronous, active-high; clears all state
- flush  in  1  discard all stored entries and this cycle's input
- in_valid  in  LANES  per-lane enqueue mask (any pattern)
- in_data  in  LANES·DATA_W  lane i at bits [i·DATA_W +: DATA_W]
- in_ready  out  1  queue can take a full LANES group this cycle
- out_valid  out  LANES  out_valid[i] = entry i (oldest-first) present
- out_data  out  LANES·DATA_W  oldest entries, lane 0 oldest
- out_deq  in  $clog2(LANES+1)  number of head entries consumed this cycle
- count  out  $clog2(DEPTH)+1  stored entry count

## Operation
- Storage: DEPTH×DATA_W array, head/tail pointers of $clog2(DEPTH) bits, wrapping modulo DEPTH; count tracked separately, range 0..DEPTH.
- n_in = popcount(in_valid) when in_ready and !flush, else 0. Valid lanes are written at tail, tail+1, … in ascending lane order; invalid lanes are skipped, so there are no holes.
- in_ready = (DEPTH − count ≥ LANES), computed from registered count only. Same-cycle dequeue never raises in_ready. Acceptance is all-or-nothing: in_valid lanes presented while in_ready=0 are dropped, and the producer must hold them.
- out_valid[i] = (count > i); out_data lane i = mem[head+i mod DEPTH]. out_data of invalid lanes is don't-care.
- n_out = min(out_deq, count). An out_deq value above the valid count is clipped, not an error.
- Update: head += n_out; tail += n_in; count ← count + n_in − n_out.
- Flush dominates: head, tail and count go to 0, and n_in is ignored.
- Enqueue and dequeue in the same cycle are both legal at any count, including full (DEPTH) and empty (0).

## Timing
- Reset (async assert, sync-safe release): head=tail=count=0, out_valid=0, in_ready=1, out_data=0.
- Enqueue-to-visible latency: 1 cycle. An entry accepted on edge N appears on out_valid from edge N.
- Dequeue takes effect on the edge at which out_deq is sampled, and the next entries appear immediately after that edge.
- Flush asserted at edge N: from edge N, count=0, out_valid=0, in_ready=1. Lane data accepted in the flush cycle is lost.
- Reset asserted mid-operation clears everything immediately, without waiting for a clock edge.
- No combinational path from in_valid or out_deq to in_ready. out_valid and out_data depend on state only, except in bypass mode.

## Configuration
- INST_QUEUE_BYPASS_EN defined:
  - When count=0 and flush=0, accepted input lanes are shown combinationally, in compacted order, on out_valid/out_data in the same cycle.
  - Bypassed entries that out_deq consumes are never written.
  - Unconsumed bypassed entries are written as normal.
  - Enqueue-to-visible latency becomes 0 when the queue is empty; otherwise it stays 1.
- Not defined: no bypass. out_* are purely from storage, and latency is always 1.

## Test plan
- Reset, then in_valid=2'b11 with data A,B, out_deq=0 → next cycle count=2, out_valid=2'b11, out_data lane0=A, lane1=B.
- in_valid=2'b10 (only lane1 = C) into empty queue → count=1, out_valid=2'b01, lane0=C (compaction).
- Fill to count=7 (DEPTH 8) → in_ready=0; a pair presented that cycle is dropped and count stays 7. Then out_deq=2 with an enqueue of 2 → count=5, the head advances 2 and the enqueue is dropped (in_ready was 0).
- Run 20 cycles of 2-in/2-out with an incrementing data pattern → output sequence strictly in order across pointer wrap, with count constant.
- count=4, flush=1 together with in_valid=2'b11 and out_deq=2 → next cycle count=0, out_valid=0, in_ready=1, and no new entries.
- With INST_QUEUE_BYPASS_EN, empty queue, in_valid=2'b11 (D,E), out_deq=1 → same cycle out_data lane0=D, then count=1 with head entry E.
